// File: rtl/sr_flag_bank_if.sv
// Bus bundle for sr_flag_bank: per-bit set/reset requests in, flag state and summaries out.
interface sr_flag_bank_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clear_all;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic             any;
  logic [CntW-1:0]  count;

  modport master (
    output s, r, clear_all,
    input  q, rise, any, count
  );

  modport slave (
    input  s, r, clear_all,
    output q, rise, any, count
  );
endinterface

// File: rtl/sr_flag_bank.sv
// Bank of independent set/reset flags with selectable s/r conflict resolution,
// optional edge-triggered set and optional per-bit auto-clear after a hold time.
module sr_flag_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      PRIORITY    = 0,
  parameter bit               EDGE_SET    = 1'b0,
  parameter int unsigned      HOLD_CYCLES = 0
) (
  input logic           clk,
  input logic           reset,
  sr_flag_bank_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_dly_q;
  logic [WIDTH-1:0] s_dly_q;
  logic [WIDTH-1:0] se;
  logic [WIDTH-1:0] expire;
  logic [CntW-1:0]  ones;

  assign se = EDGE_SET ? (bus.s & ~s_dly_q) : bus.s;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.clear_all) begin
        q_d[i] = 1'b0;
      end else if (se[i] && bus.r[i]) begin
        if (PRIORITY == 2) begin
          q_d[i] = ~q_q[i];
        end else if (PRIORITY == 1) begin
          q_d[i] = 1'b1;
        end else begin
          q_d[i] = 1'b0;
        end
      end else if (se[i]) begin
        q_d[i] = 1'b1;
      end else if (bus.r[i]) begin
        q_d[i] = 1'b0;
      end else if (expire[i]) begin
        q_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= RESET_VALUE;
      q_dly_q <= RESET_VALUE;
      s_dly_q <= '0;
    end else begin
      q_q     <= q_d;
      q_dly_q <= q_q;
      s_dly_q <= bus.s;
    end
  end

  if (HOLD_CYCLES > 0) begin : g_hold
    localparam logic [7:0] HoldVal = 8'(HOLD_CYCLES);

    logic [7:0] cnt_q [WIDTH];
    logic [7:0] cnt_d [WIDTH];

    always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
        expire[i] = q_q[i] && (cnt_q[i] == 8'd1);
      end
    end

    // Any set that leaves the bit high reloads, so retrigger and set-on-expiry both win.
    always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
        if (q_d[i]) begin
          if (se[i]) begin
            cnt_d[i] = HoldVal;
          end else if (cnt_q[i] != 8'd0) begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (reset) begin
          cnt_q[i] <= RESET_VALUE[i] ? HoldVal : 8'd0;
        end else begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end
  end else begin : g_no_hold
    assign expire = '0;
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CntW'(q_q[i]);
    end
  end

  assign bus.q     = q_q;
  assign bus.rise  = q_q & ~q_dly_q;
  assign bus.any   = |q_q;
  assign bus.count = ones;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Bench for sr_flag_bank: six parameter variants share one stimulus stream; directed
// scenarios check fixed expectations, a random phase checks against a deadline-based model.
module tb_sr_flag_bank;

  localparam int NDUT = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_drv, r_drv;
  logic       ca_drv;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  sr_flag_bank_if #(.WIDTH(8)) if0 ();
  sr_flag_bank_if #(.WIDTH(8)) if1 ();
  sr_flag_bank_if #(.WIDTH(8)) if2 ();
  sr_flag_bank_if #(.WIDTH(8)) if3 ();
  sr_flag_bank_if #(.WIDTH(8)) if4 ();
  sr_flag_bank_if #(.WIDTH(8)) if5 ();

  sr_flag_bank #(.WIDTH(8)) u0 (.clk(clk), .reset(rst), .bus(if0));
  sr_flag_bank #(.WIDTH(8), .PRIORITY(1)) u1 (.clk(clk), .reset(rst), .bus(if1));
  sr_flag_bank #(.WIDTH(8), .PRIORITY(2)) u2 (.clk(clk), .reset(rst), .bus(if2));
  sr_flag_bank #(.WIDTH(8), .EDGE_SET(1'b1)) u3 (.clk(clk), .reset(rst), .bus(if3));
  sr_flag_bank #(.WIDTH(8), .HOLD_CYCLES(3)) u4 (.clk(clk), .reset(rst), .bus(if4));
  sr_flag_bank #(.WIDTH(8), .RESET_VALUE(8'h81), .PRIORITY(2), .EDGE_SET(1'b1),
                 .HOLD_CYCLES(3)) u5 (.clk(clk), .reset(rst), .bus(if5));

  always_comb begin
    if0.s = s_drv; if0.r = r_drv; if0.clear_all = ca_drv;
    if1.s = s_drv; if1.r = r_drv; if1.clear_all = ca_drv;
    if2.s = s_drv; if2.r = r_drv; if2.clear_all = ca_drv;
    if3.s = s_drv; if3.r = r_drv; if3.clear_all = ca_drv;
    if4.s = s_drv; if4.r = r_drv; if4.clear_all = ca_drv;
    if5.s = s_drv; if5.r = r_drv; if5.clear_all = ca_drv;
  end

  logic [7:0] dq    [NDUT];
  logic [7:0] drise [NDUT];
  logic       dany  [NDUT];
  logic [3:0] dcnt  [NDUT];

  always_comb begin
    dq[0] = if0.q; drise[0] = if0.rise; dany[0] = if0.any; dcnt[0] = if0.count;
    dq[1] = if1.q; drise[1] = if1.rise; dany[1] = if1.any; dcnt[1] = if1.count;
    dq[2] = if2.q; drise[2] = if2.rise; dany[2] = if2.any; dcnt[2] = if2.count;
    dq[3] = if3.q; drise[3] = if3.rise; dany[3] = if3.any; dcnt[3] = if3.count;
    dq[4] = if4.q; drise[4] = if4.rise; dany[4] = if4.any; dcnt[4] = if4.count;
    dq[5] = if5.q; drise[5] = if5.rise; dany[5] = if5.any; dcnt[5] = if5.count;
  end

  // Reference model: each flag remembers the edge number at which it must expire.
  int         prio_c [NDUT] = '{0, 1, 2, 0, 0, 2};
  bit         edge_c [NDUT] = '{0, 0, 0, 1, 0, 1};
  int         hold_c [NDUT] = '{0, 0, 0, 0, 3, 3};
  logic [7:0] rv_c   [NDUT] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
  logic [7:0] m_q    [NDUT];
  logic [7:0] m_qp   [NDUT];
  logic [7:0] m_sp   [NDUT];
  int         m_dl   [NDUT][8];
  int         edge_no = 0;

  task automatic model_step();
    for (int d = 0; d < NDUT; d++) begin
      logic [7:0] nq;
      if (rst) begin
        m_q[d]  = rv_c[d];
        m_qp[d] = rv_c[d];
        m_sp[d] = '0;
        for (int i = 0; i < 8; i++) m_dl[d][i] = edge_no + hold_c[d];
      end else begin
        nq = m_q[d];
        for (int i = 0; i < 8; i++) begin
          bit se;
          se = s_drv[i] && !(edge_c[d] && m_sp[d][i]);
          if (ca_drv) nq[i] = 1'b0;
          else if (se && r_drv[i]) nq[i] = (prio_c[d] == 0) ? 1'b0 :
                                            (prio_c[d] == 1) ? 1'b1 : !m_q[d][i];
          else if (se) nq[i] = 1'b1;
          else if (r_drv[i]) nq[i] = 1'b0;
          else if (hold_c[d] > 0 && m_q[d][i] && edge_no == m_dl[d][i]) nq[i] = 1'b0;
          if (se && nq[i]) m_dl[d][i] = edge_no + hold_c[d];
        end
        m_qp[d] = m_q[d];
        m_sp[d] = s_drv;
        m_q[d]  = nq;
      end
    end
    edge_no++;
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_drv = '0; r_drv = '0; ca_drv = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_drv = 8'hFF; r_drv = '0; ca_drv = 1'b0;
    cyc();
    rst = 1'b0; s_drv = '0;
    n_cmp++; if (if0.q !== 8'h00) begin n_fail++; $display("FAIL reset_q0 got %h want 00", if0.q); end
    n_cmp++; if (if0.rise !== 8'h00) begin n_fail++; $display("FAIL reset_rise0 got %h want 00", if0.rise); end
    n_cmp++; if (if0.any !== 1'b0) begin n_fail++; $display("FAIL reset_any0 got %b want 0", if0.any); end
    n_cmp++; if (if0.count !== 4'd0) begin n_fail++; $display("FAIL reset_cnt0 got %0d want 0", if0.count); end
    n_cmp++; if (if1.q !== 8'h00) begin n_fail++; $display("FAIL reset_q1 got %h want 00", if1.q); end
    n_cmp++; if (if5.q !== 8'h81) begin n_fail++; $display("FAIL reset_q5 got %h want 81", if5.q); end
    n_cmp++; if (if5.rise !== 8'h00) begin n_fail++; $display("FAIL reset_rise5 got %h want 00", if5.rise); end
    n_cmp++; if (if5.count !== 4'd2) begin n_fail++; $display("FAIL reset_cnt5 got %0d want 2", if5.count); end
    cyc();
    n_cmp++; if (if5.q !== 8'h81) begin n_fail++; $display("FAIL rv_hold1 got %h want 81", if5.q); end
    cyc();
    cyc();
    n_cmp++; if (if5.q !== 8'h00) begin n_fail++; $display("FAIL rv_expire got %h want 00", if5.q); end
  endtask

  task automatic test_set_basic();
    do_reset();
    s_drv = 8'h05;
    cyc();
    s_drv = '0;
    n_cmp++; if (if0.q !== 8'h05) begin n_fail++; $display("FAIL set_q got %h want 05", if0.q); end
    n_cmp++; if (if0.rise !== 8'h05) begin n_fail++; $display("FAIL set_rise got %h want 05", if0.rise); end
    n_cmp++; if (if0.any !== 1'b1) begin n_fail++; $display("FAIL set_any got %b want 1", if0.any); end
    n_cmp++; if (if0.count !== 4'd2) begin n_fail++; $display("FAIL set_cnt got %0d want 2", if0.count); end
    cyc();
    n_cmp++; if (if0.q !== 8'h05) begin n_fail++; $display("FAIL set_hold got %h want 05", if0.q); end
    n_cmp++; if (if0.rise !== 8'h00) begin n_fail++; $display("FAIL rise_once got %h want 00", if0.rise); end
  endtask

  task automatic test_priority();
    do_reset();
    s_drv = 8'h01;
    cyc();
    r_drv = 8'h01;
    cyc();
    n_cmp++; if (if0.q[0] !== 1'b0) begin n_fail++; $display("FAIL prio0_from1 got %b want 0", if0.q[0]); end
    n_cmp++; if (if1.q[0] !== 1'b1) begin n_fail++; $display("FAIL prio1_from1 got %b want 1", if1.q[0]); end
    n_cmp++; if (if2.q[0] !== 1'b0) begin n_fail++; $display("FAIL prio2_from1 got %b want 0", if2.q[0]); end
    s_drv = '0;
    cyc();
    s_drv = 8'h01;
    cyc();
    s_drv = '0; r_drv = '0;
    n_cmp++; if (if0.q[0] !== 1'b0) begin n_fail++; $display("FAIL prio0_from0 got %b want 0", if0.q[0]); end
    n_cmp++; if (if1.q[0] !== 1'b1) begin n_fail++; $display("FAIL prio1_from0 got %b want 1", if1.q[0]); end
    n_cmp++; if (if2.q[0] !== 1'b1) begin n_fail++; $display("FAIL prio2_from0 got %b want 1", if2.q[0]); end
  endtask

  task automatic test_edge_set();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      s_drv = 8'h08;
      r_drv = (k == 4) ? 8'h08 : 8'h00;
      cyc();
      n_cmp++;
      if (if3.q[3] !== (k < 4)) begin
        n_fail++; $display("FAIL edge_q3 k=%0d got %b want %b", k, if3.q[3], k < 4);
      end
      n_cmp++;
      if (if3.rise[3] !== (k == 0)) begin
        n_fail++; $display("FAIL edge_rise3 k=%0d got %b want %b", k, if3.rise[3], k == 0);
      end
      n_cmp++;
      if (if0.q[3] !== (k != 4)) begin
        n_fail++; $display("FAIL level_q3 k=%0d got %b want %b", k, if0.q[3], k != 4);
      end
    end
    s_drv = '0; r_drv = '0;
  endtask

  task automatic test_hold();
    do_reset();
    s_drv = 8'h02;
    cyc();
    s_drv = '0;
    n_cmp++; if (if4.q[1] !== 1'b1) begin n_fail++; $display("FAIL hold_t0 got %b want 1", if4.q[1]); end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      n_cmp++;
      if (if4.q[1] !== (k < 3)) begin
        n_fail++; $display("FAIL hold_t%0d got %b want %b", k, if4.q[1], k < 3);
      end
    end
    s_drv = 8'h02;
    cyc();
    for (int k = 1; k <= 5; k++) begin
      s_drv = (k == 2) ? 8'h02 : 8'h00;
      cyc();
      n_cmp++;
      if (if4.q[1] !== (k < 5)) begin
        n_fail++; $display("FAIL retrig_t%0d got %b want %b", k, if4.q[1], k < 5);
      end
    end
    s_drv = 8'h02;
    cyc();
    s_drv = '0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++; if (if4.q !== 8'h00) begin n_fail++; $display("FAIL midhold_rst got %h want 00", if4.q); end
  endtask

  task automatic test_clear_all();
    do_reset();
    s_drv = 8'hFF;
    cyc();
    n_cmp++; if (if0.q !== 8'hFF) begin n_fail++; $display("FAIL fill_q got %h want ff", if0.q); end
    n_cmp++; if (if0.count !== 4'd8) begin n_fail++; $display("FAIL fill_cnt got %0d want 8", if0.count); end
    ca_drv = 1'b1;
    cyc();
    ca_drv = 1'b0; s_drv = '0;
    n_cmp++; if (if0.q !== 8'h00) begin n_fail++; $display("FAIL clr_q got %h want 00", if0.q); end
    n_cmp++; if (if0.count !== 4'd0) begin n_fail++; $display("FAIL clr_cnt got %0d want 0", if0.count); end
    n_cmp++; if (if1.q !== 8'h00) begin n_fail++; $display("FAIL clr_q1 got %h want 00", if1.q); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      s_drv  = 8'($urandom & $urandom);
      r_drv  = 8'($urandom & $urandom & $urandom);
      ca_drv = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 49) == 0);
      cyc();
      for (int d = 0; d < NDUT; d++) begin
        n_cmp++;
        if (dq[d] !== m_q[d]) begin
          n_fail++; $display("FAIL rnd_q dut%0d n=%0d got %h want %h", d, n, dq[d], m_q[d]);
        end
        n_cmp++;
        if (drise[d] !== (m_q[d] & ~m_qp[d])) begin
          n_fail++;
          $display("FAIL rnd_rise dut%0d n=%0d got %h want %h", d, n, drise[d], m_q[d] & ~m_qp[d]);
        end
        n_cmp++;
        if (dany[d] !== (m_q[d] != 0)) begin
          n_fail++; $display("FAIL rnd_any dut%0d n=%0d got %b want %b", d, n, dany[d], m_q[d] != 0);
        end
        n_cmp++;
        if (dcnt[d] !== 4'($countones(m_q[d]))) begin
          n_fail++;
          $display("FAIL rnd_cnt dut%0d n=%0d got %0d want %0d", d, n, dcnt[d], $countones(m_q[d]));
        end
      end
    end
    rst = 1'b0; s_drv = '0; r_drv = '0; ca_drv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_drv = '0; r_drv = '0; ca_drv = 1'b0;
    @(negedge clk);
    test_reset();
    test_set_basic();
    test_priority();
    test_edge_set();
    test_hold();
    test_clear_all();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
